// File: rtl/c_split2_sync_if.sv
// c_split2_sync_if: handshake/data bundle for the two-way token splitter.
//   Upstream:   i_drive, i_data, i_sel  -> splitter;  o_free  <- splitter
//   Channel 0:  o_drive0, o_data0       <- splitter;  i_free0 -> splitter
//   Channel 1:  o_drive1, o_data1       <- splitter;  i_free1 -> splitter
//   Status:     o_cnt0, o_cnt1, o_err   <- splitter
// Modports: slave = the splitter itself, master = its environment.
interface c_split2_sync_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                  i_drive;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  i_sel;
    logic                  o_free;
    logic                  o_drive0;
    logic                  o_drive1;
    logic [DATA_WIDTH-1:0] o_data0;
    logic [DATA_WIDTH-1:0] o_data1;
    logic                  i_free0;
    logic                  i_free1;
    logic [CNT_WIDTH-1:0]  o_cnt0;
    logic [CNT_WIDTH-1:0]  o_cnt1;
    logic                  o_err;

    modport slave (
        input  i_drive, i_data, i_sel, i_free0, i_free1,
        output o_free, o_drive0, o_drive1, o_data0, o_data1, o_cnt0, o_cnt1, o_err
    );

    modport master (
        output i_drive, i_data, i_sel, i_free0, i_free1,
        input  o_free, o_drive0, o_drive1, o_data0, o_data1, o_cnt0, o_cnt1, o_err
    );
endinterface

// File: rtl/c_split2_sync.sv
// c_split2_sync: clocked two-output token splitter.
//   One upstream drive/free channel is routed by i_sel to one of two
//   downstream drive/free channels. A 2-entry FIFO lets upstream be freed
//   before its token is consumed downstream.
// Ports:
//   clk   - clock, rising edge
//   rstn  - asynchronous active-low reset
//   bus   - c_split2_sync_if.slave (upstream, two downstream channels,
//           per-channel completion counters, sticky error flag)
module c_split2_sync #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic             clk,
    input  logic             rstn,
    c_split2_sync_if.slave   bus
);

    typedef struct packed {
        logic                  sel;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t state, state_nxt;

    entry_t     mem [2];
    logic       wr_ptr, rd_ptr;
    logic [1:0] count, count_nxt;
    logic       credit;
    logic       free_q;
    logic       err_q;

    entry_t     head;
    logic       active;
    logic       push, pop, err_set;
    logic [1:0] free_v;
    logic [1:0] drive_v;
    logic [1:0][DATA_WIDTH-1:0] data_v;
    logic [1:0][CNT_WIDTH-1:0]  cnt;

    assign head   = mem[rd_ptr];
    assign active = (state != IDLE);
    assign free_v = {bus.i_free1, bus.i_free0};

    // Upstream accept, head completion and protocol-error detection.
    always_comb begin
        push      = bus.i_drive && credit;
        pop       = active && free_v[head.sel];
        err_set   = (bus.i_drive && !credit)
                  || (!active && (|free_v))
                  || (active && free_v[~head.sel]);
        count_nxt = 2'(count + {1'b0, push} - {1'b0, pop});
    end

    // Next-state logic. From IDLE an incoming push into an empty FIFO
    // already counts as a valid head, giving drive one cycle after i_drive.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (count != 2'd0 || push) state_nxt = DRIVE;
            DRIVE:   state_nxt = pop ? IDLE : WAIT;
            WAIT:    if (pop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // FIFO storage and pointers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{sel: bus.i_sel, data: bus.i_data};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count_nxt;
        end
    end

    // Upstream credit. A push that leaves a free slot is freed at once, so
    // credit never actually drops. A push that fills the FIFO holds credit
    // low; the next pop returns it together with the deferred free pulse.
    // No push can occur while credit is low, so the two cases never collide.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            credit <= 1'b1;
            free_q <= 1'b0;
        end else begin
            free_q <= (push && count_nxt != 2'd2) || (!credit && pop);
            if (push)
                credit <= (count_nxt != 2'd2);
            else if (!credit && pop)
                credit <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)        err_q <= 1'b0;
        else if (err_set) err_q <= 1'b1;
    end

    // Per-channel drive/data decode and completion counters.
    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic hit;
        assign hit         = (head.sel == 1'(ch));
        assign drive_v[ch] = (state == DRIVE) && hit;
        assign data_v[ch]  = (active && hit) ? head.data : '0;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn)               cnt[ch] <= '0;
            else if (pop && hit)     cnt[ch] <= cnt[ch] + 1'b1;
        end
    end

    assign bus.o_free   = free_q;
    assign bus.o_drive0 = drive_v[0];
    assign bus.o_drive1 = drive_v[1];
    assign bus.o_data0  = data_v[0];
    assign bus.o_data1  = data_v[1];
    assign bus.o_cnt0   = cnt[0];
    assign bus.o_cnt1   = cnt[1];
    assign bus.o_err    = err_q;

endmodule
